// File: rtl/serial_accum_pkg.sv
// serial_accum_pkg: shared constants, bit-counter states and counter-width helper for serial blocks.
package serial_accum_pkg;
   localparam logic SYNC_ACTIVE = 1'b1;
   localparam int DEF_LEN = 10;
   typedef enum logic {S_IDLE, S_BUSY} bit_state_t;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/serial_accum_if.sv
// serial_accum_if: LSB-first serial data in/out with framing syncs and status flags.
interface serial_accum_if;
   logic i;
   logic isync;
   logic q;
   logic osync;
   logic ovf;
   logic err;
   modport master(output i, isync, input q, osync, ovf, err);
   modport slave(input i, isync, output q, osync, ovf, err);
endinterface

// File: rtl/serial_accum_fa.sv
// serial_fa: one-bit full adder with registered carry and synchronous carry-clear.
module serial_fa (
   input  logic clk,
   input  logic reset,
   input  logic i_a,
   input  logic i_b,
   input  logic i_en,
   input  logic i_clr,
   output logic o_s,
   output logic o_c
);
   logic r_c;
   logic w_cin;
   assign w_cin = i_clr ? 1'b0 : r_c;
   assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {1'b0, w_cin};
   always_ff @(posedge clk)
      if (reset) r_c <= 1'b0;
      else if (i_en) r_c <= o_c;
endmodule

// File: rtl/serial_accum.sv
// serial_accum: sums NACC LSB-first serial words into an ACCW-bit total and
// shifts the total back out serially with its own sync pulse.
module serial_accum
   import serial_accum_pkg::*;
#(
   parameter int LEN  = DEF_LEN,
   parameter int ACCW = 16,
   parameter int NACC = 4
) (
   input  logic clk,
   input  logic reset,
   serial_accum_if.slave bus
);
   localparam int KW = cnt_w(ACCW);
   localparam int WW = cnt_w(NACC + 1);
   localparam logic [KW-1:0] K_LAST = KW'(ACCW - 1);
   localparam logic [KW:0]   K_LEN  = (KW + 1)'(LEN);
   localparam logic [WW-1:0] W_LAST = WW'(NACC - 1);

   bit_state_t r_state, w_state_nx;
   logic [KW-1:0]   r_k, w_k;
   logic [WW-1:0]   r_wcnt;
   logic [ACCW-1:0] r_acc, r_sh, w_acc_nx;
   logic r_win_ovf, r_osync, r_ovf, r_err;
   logic w_start, w_active, w_last, w_dump, w_in, w_s, w_c;

   // cycle 0 of a word is the isync cycle itself, so it is handled before r_state turns busy
   always_comb begin
      w_start    = (bus.isync == SYNC_ACTIVE) && (r_state == S_IDLE);
      w_active   = w_start || (r_state == S_BUSY);
      w_k        = (r_state == S_BUSY) ? r_k : '0;
      w_in       = w_active && ({1'b0, w_k} < K_LEN) && bus.i;
      w_last     = w_active && (w_k == K_LAST);
      w_dump     = w_last && (r_wcnt == W_LAST);
      w_state_nx = w_last ? S_IDLE : (w_active ? S_BUSY : r_state);
      w_acc_nx   = {w_s, r_acc[ACCW-1:1]};
   end

   serial_fa u_fa (
      .clk   (clk),
      .reset (reset),
      .i_a   (r_acc[0]),
      .i_b   (w_in),
      .i_en  (w_active),
      .i_clr (w_start),
      .o_s   (w_s),
      .o_c   (w_c)
   );

   always_ff @(posedge clk)
      r_state <= reset ? S_IDLE : w_state_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_k       <= '0;
         r_wcnt    <= '0;
         r_acc     <= '0;
         r_sh      <= '0;
         r_win_ovf <= 1'b0;
         r_osync   <= 1'b0;
         r_ovf     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_active) begin
            r_k   <= w_k + 1'b1;
            r_acc <= w_dump ? '0 : w_acc_nx;
         end
         if (w_last) begin
            r_wcnt    <= w_dump ? '0 : r_wcnt + 1'b1;
            r_win_ovf <= !w_dump && (r_win_ovf || w_c);
         end
         // the final rotated value including this cycle's sum bit is the window total
         if (w_dump) begin
            r_sh  <= w_acc_nx;
            r_ovf <= r_win_ovf || w_c;
         end else begin
            r_sh <= r_sh >> 1;
         end
         r_osync <= w_dump;
         if (bus.isync && r_state == S_BUSY) r_err <= 1'b1;
      end
   end

   assign bus.q     = r_sh[0];
   assign bus.osync = r_osync;
   assign bus.ovf   = r_ovf;
   assign bus.err   = r_err;
endmodule
